// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin, burst-bounded sharing of the single write
// port of the master-side async FIFO. Runs entirely in the clk_master domain.
//
// state | meaning
// IDLE  | no grant held; arbitrate among req_valid starting at rr_ptr
// GRANT | grant_id owns the write port until its burst ends or its valid drops
module fifo_write_arbiter #(
  parameter int  NUM_REQ    = 4,
  parameter int  DATA_WIDTH = 8,
  parameter int  BURST_MAX  = 4,
  localparam int IDW        = $clog2(NUM_REQ)
) (
  input  logic                          clk_master,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          full,
  output logic                          w_en,
  output logic [DATA_WIDTH-1:0]         fifo_wdata,
  output logic [IDW-1:0]                grant_id,
  output logic                          busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [IDW:0] NUM_REQ_W = (IDW+1)'(NUM_REQ);
  localparam logic [3:0]   LAST_BEAT = 4'(BURST_MAX - 1);

  state_t                state_q, state_d;
  logic [IDW-1:0]        grant_id_q, grant_id_d;
  logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [3:0]            beat_cnt_q, beat_cnt_d;

  logic [DATA_WIDTH-1:0] word [NUM_REQ];
  logic                  sel_found;
  logic [IDW-1:0]        sel_idx;
  logic [IDW:0]          cand;
  logic [IDW:0]          inc;

  // Slice the flat request bus into one word per requester.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      word[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // First valid requester searching upward from rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
      if (!sel_found && req_valid[cand[IDW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[IDW-1:0];
      end
    end
  end

  // Next state and zero-latency write-port outputs for the held grant.
  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    req_ready  = '0;
    w_en       = 1'b0;
    fifo_wdata = '0;
    inc        = {1'b0, grant_id_q} + (IDW+1)'(1);
    if (inc >= NUM_REQ_W) inc = '0;

    case (state_q)
      IDLE: begin
        if (sel_found) begin
          grant_id_d = sel_idx;
          beat_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        req_ready[grant_id_q] = !full;
        w_en                  = req_valid[grant_id_q] && !full;
        if (w_en) fifo_wdata = word[grant_id_q];
        // A vanished request releases even while full stalls the port.
        if (!req_valid[grant_id_q]) begin
          state_d  = IDLE;
          rr_ptr_d = inc[IDW-1:0];
        end else if (w_en) begin
          beat_cnt_d = beat_cnt_q + 4'd1;
          if (beat_cnt_q == LAST_BEAT) begin
            state_d  = IDLE;
            rr_ptr_d = inc[IDW-1:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset forces IDLE so all port outputs drop immediately.
  always_ff @(posedge clk_master or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      grant_id_q <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign busy     = (state_q == GRANT);
  assign grant_id = grant_id_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: directed scenarios, a grant/beat-level model
// checked every cycle, and literal expectations on word order and timing.
module tb_fifo_write_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int BM = 4;

  logic            clk_master = 1'b0;
  logic            reset_n    = 1'b0;
  logic            full       = 1'b0;
  logic [N-1:0]    req_valid  = '0;
  logic [N*DW-1:0] req_data   = '0;
  logic [N-1:0]    req_ready;
  logic            w_en;
  logic [DW-1:0]   fifo_wdata;
  logic [1:0]      grant_id;
  logic            busy;

  int n_cmp = 0;
  int n_err = 0;

  int           src [N][$];
  logic [N-1:0] hold    = '0;
  logic [N-1:0] hs_mask = '0;
  int           wq[$];
  int           gq[$];
  int           exp_q[$];
  logic [31:0]  wen_hist  = '0;
  logic [31:0]  busy_hist = '0;
  bit           prev_busy = 1'b0;

  bit m_busy  = 1'b0;
  int m_gid   = 0;
  int m_ptr   = 0;
  int m_beats = 0;

  fifo_write_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .BURST_MAX(BM)) dut (
    .clk_master (clk_master),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .full       (full),
    .w_en       (w_en),
    .fifo_wdata (fifo_wdata),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  always #5 clk_master = ~clk_master;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: expected outputs this cycle, then what the coming edge does.
  always @(negedge clk_master) begin
    bit live;
    bit found;
    int e_ready, e_wen, e_data, e_busy, e_gid;
    live    = reset_n && m_busy;
    e_busy  = live ? 1 : 0;
    e_gid   = reset_n ? m_gid : 0;
    e_ready = (live && !full) ? (1 << m_gid) : 0;
    e_wen   = (live && req_valid[m_gid] && !full) ? 1 : 0;
    e_data  = (e_wen != 0) ? int'(req_data[m_gid*DW +: DW]) : 0;
    chk("w_en",       int'(w_en),       e_wen);
    chk("req_ready",  int'(req_ready),  e_ready);
    chk("fifo_wdata", int'(fifo_wdata), e_data);
    chk("busy",       int'(busy),       e_busy);
    chk("grant_id",   int'(grant_id),   e_gid);

    if (w_en) wq.push_back(int'(fifo_wdata));
    if (busy && !prev_busy) gq.push_back(int'(grant_id));
    prev_busy = busy;
    hs_mask   = req_ready & req_valid;
    wen_hist  = {wen_hist[30:0], w_en};
    busy_hist = {busy_hist[30:0], busy};

    if (!reset_n) begin
      m_busy = 1'b0; m_gid = 0; m_ptr = 0; m_beats = 0;
    end else if (!m_busy) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (!found && req_valid[(m_ptr + k) % N]) begin
          found = 1'b1;
          m_gid = (m_ptr + k) % N;
        end
      end
      if (found) begin
        m_busy  = 1'b1;
        m_beats = 0;
      end
    end else if (!req_valid[m_gid]) begin
      m_busy = 1'b0;
      m_ptr  = (m_gid + 1) % N;
    end else if (!full) begin
      m_beats++;
      if (m_beats == BM) begin
        m_busy = 1'b0;
        m_ptr  = (m_gid + 1) % N;
      end
    end
  end

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]           = (src[i].size() > 0) && !hold[i];
      req_data[i*DW +: DW]   = (src[i].size() > 0) ? DW'(src[i][0]) : '0;
    end
  endtask

  task automatic step();
    @(posedge clk_master);
    #1;
    for (int i = 0; i < N; i++) begin
      if (hs_mask[i] && src[i].size() > 0) void'(src[i].pop_front());
    end
    drive();
  endtask

  task automatic reset_dut();
    reset_n = 1'b0;
    hold    = '0;
    full    = 1'b0;
    for (int i = 0; i < N; i++) src[i].delete();
    drive();
    repeat (2) step();
    reset_n = 1'b1;
    wq.delete();
    gq.delete();
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    bit done;
    n = 0;
    while ((req_valid != '0 || busy) && n < budget) begin
      step();
      n++;
    end
    done = (req_valid == '0) && !busy;
    chk({name, "_drained"}, int'(done), 1);
    repeat (2) step();
  endtask

  task automatic check_q(input string name, input bit sel_g);
    int got[$];
    got = sel_g ? gq : wq;
    chk({name, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      chk(name, (i < got.size()) ? got[i] : -1, exp_q[i]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    drive();
    repeat (2) step();
    @(negedge clk_master);
    #1;
    chk("rst_w_en",      int'(w_en),       0);
    chk("rst_busy",      int'(busy),       0);
    chk("rst_req_ready", int'(req_ready),  0);
    chk("rst_wdata",     int'(fifo_wdata), 0);
    chk("rst_grant_id",  int'(grant_id),   0);

    // A: requester 0 alone, six words, burst of four
    reset_dut();
    for (int k = 0; k < 6; k++) src[0].push_back(8'h10 + k);
    drive();
    repeat (10) step();
    chk("A_wen_trace",  int'(wen_hist[9:0]),  10'b0111101100);
    chk("A_busy_trace", int'(busy_hist[9:0]), 10'b0111101110);
    exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    check_q("A_words", 1'b0);
    exp_q = '{0, 0};
    check_q("A_grants", 1'b1);

    // B: all four requesters valid, full rotation
    reset_dut();
    for (int k = 0; k < 8; k++) src[0].push_back(8'hA0 + k);
    for (int k = 0; k < 4; k++) src[1].push_back(8'hB0 + k);
    for (int k = 0; k < 4; k++) src[2].push_back(8'hC0 + k);
    for (int k = 0; k < 4; k++) src[3].push_back(8'hD0 + k);
    drive();
    repeat (25) step();
    chk("B_wen_trace", int'(wen_hist[24:0]), {5{5'b01111}});
    drain("B", 40);
    exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3,
              8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hD0, 8'hD1, 8'hD2, 8'hD3,
              8'hA4, 8'hA5, 8'hA6, 8'hA7};
    check_q("B_words", 1'b0);
    exp_q = '{0, 1, 2, 3, 0};
    check_q("B_grants", 1'b1);

    // C: requester 2 stalled by full for five cycles after its first beat
    reset_dut();
    for (int k = 0; k < 4; k++) src[2].push_back(8'h20 + k);
    drive();
    repeat (2) step();
    full = 1'b1;
    drive();
    repeat (5) step();
    full = 1'b0;
    drive();
    repeat (4) step();
    chk("C_wen_trace",  int'(wen_hist[10:0]),  11'b01000001110);
    chk("C_busy_trace", int'(busy_hist[10:0]), 11'b01111111110);
    exp_q = '{8'h20, 8'h21, 8'h22, 8'h23};
    check_q("C_words", 1'b0);

    // D: requester 1 drops valid after two beats while 3 waits
    reset_dut();
    for (int k = 0; k < 4; k++) src[1].push_back(8'h40 + k);
    src[3].push_back(8'h60);
    src[3].push_back(8'h61);
    drive();
    repeat (3) step();
    hold[1] = 1'b1;
    drive();
    step();
    hold[1] = 1'b0;
    drive();
    drain("D", 40);
    exp_q = '{8'h40, 8'h41, 8'h60, 8'h61, 8'h42, 8'h43};
    check_q("D_words", 1'b0);
    exp_q = '{1, 3, 1};
    check_q("D_grants", 1'b1);

    // E: requester 3 completes its burst, pointer wraps to 0
    reset_dut();
    hold[0] = 1'b1;
    for (int k = 0; k < 6; k++) src[3].push_back(8'h70 + k);
    src[0].push_back(8'h30);
    drive();
    step();
    hold[0] = 1'b0;
    drive();
    drain("E", 40);
    exp_q = '{8'h70, 8'h71, 8'h72, 8'h73, 8'h30, 8'h74, 8'h75};
    check_q("E_words", 1'b0);
    exp_q = '{3, 0, 3};
    check_q("E_grants", 1'b1);

    // F: reset asserted mid-burst after beat 2
    reset_dut();
    for (int k = 0; k < 4; k++) src[2].push_back(8'h80 + k);
    drive();
    repeat (3) step();
    reset_n = 1'b0;
    #1;
    chk("F_async_w_en",  int'(w_en),      0);
    chk("F_async_busy",  int'(busy),      0);
    chk("F_async_ready", int'(req_ready), 0);
    src[0].push_back(8'h90);
    drive();
    repeat (2) step();
    reset_n = 1'b1;
    drive();
    drain("F", 40);
    exp_q = '{8'h80, 8'h81, 8'h90, 8'h82, 8'h83};
    check_q("F_words", 1'b0);
    exp_q = '{2, 0, 2};
    check_q("F_grants", 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Shares the single write port of the master-side asynchronous FIFO between NUM_REQ requesters.
- Arbitration is round-robin with a bounded burst per grant, so no requester can monopolise the FIFO.
- Drives the FIFO w_en/data_in pins and honours the FIFO full flag; it runs entirely in the clk_master domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 8, FIFO word width.
- BURST_MAX, 4, maximum beats per grant before rotation (1..15).

Ports:
- clk_master  in  1  master-side clock; all state is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  bit i = requester i has a word.
- req_data  in  NUM_REQ*DATA_WIDTH  requester i word at [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  bit i = requester i word accepted this cycle when valid.
- full  in  1  FIFO write-side full flag.
- w_en  out  1  FIFO write enable.
- fifo_wdata  out  DATA_WIDTH  FIFO write data.
- grant_id  out  clog2(NUM_REQ)  index of the current or last granted requester.
- busy  out  1  high while a grant is held.

Behaviour:
- States: IDLE, GRANT.
  - Registered: state, grant_id, rr_ptr (clog2(NUM_REQ) bits), beat_cnt (4 bits).
- Reset (reset_n low, asynchronous):
  - state=IDLE; grant_id=0; rr_ptr=0; beat_cnt=0.
  - Outputs follow combinationally: w_en=0, req_ready=0, busy=0, fifo_wdata=0.
- IDLE:
  - If any req_valid bit is set, select the first set bit searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - Next edge: grant_id<=selected, beat_cnt<=0, state<=GRANT.
  - No transfer occurs in IDLE, so every grant costs one arbitration bubble cycle.
  - If no bit is set, stay in IDLE.
- GRANT, combinational outputs (g = grant_id):
  - req_ready[g] = !full; all other ready bits = 0.
  - w_en = req_valid[g] && !full.
  - fifo_wdata = req_data[g]; it is 0 whenever w_en=0.
  - Zero latency: the beat is written on the same edge as the handshake, so a sampled-high full can never be overrun.
- GRANT, sequential:
  - A beat is transferred on each edge where w_en=1; beat_cnt increments on each beat.
  - Release to IDLE with rr_ptr<=(g+1) mod NUM_REQ when either:
    - a beat transfers and beat_cnt==BURST_MAX-1 (burst exhausted), or
    - req_valid[g]==0 on that edge, whether or not full is high.
  - full high with valid high: stall. No beat, beat_cnt holds, grant holds indefinitely; there is no timeout.
- Simultaneous events:
  - Final beat and full rising on the same cycle: the beat counts only if w_en was high at the edge.
  - Requests from non-granted requesters are ignored until the next IDLE.
- busy = (state==GRANT).
- grant_id holds its last value in IDLE.
- Requester contract: req_data[i] stays stable while req_valid[i]=1 and req_ready[i]=0. The arbiter does not buffer data.
- Reset mid-burst:
  - w_en drops asynchronously with reset_n; no partial write.
  - The beat count is lost, and arbitration restarts from requester 0.

Test Plan:
- Requester 0 only, valid for 6 words 0x10..0x15, BURST_MAX=4, full=0:
  - w_en high for 4 cycles writing 0x10..0x13, then 1 IDLE cycle, then grant 0 again for 0x14..0x15.
  - busy drops after the final beat.
- All four requesters continuously valid, full=0:
  - grant_id sequence 0,1,2,3,0 with 4 beats each and one bubble cycle between grants.
  - Each requester's words arrive in order.
- Requester 2 granted, full forced high for 5 cycles after beat 1:
  - w_en=0 and req_ready=0 for those 5 cycles; beat_cnt holds at 1.
  - Beats 2..4 complete after full drops.
  - FIFO receives exactly 4 words, none duplicated.
- Requester 1 drops valid after 2 beats while requester 3 is waiting:
  - Release on that edge, IDLE cycle, then grant_id=3.
  - rr_ptr advances to 2 on release.
- Grant to requester 3 completes while requesters 0 and 3 are both valid: rr_ptr wraps to 0, so the next grant_id=0.
- reset_n asserted mid-burst (after beat 2):
  - w_en, req_ready and busy go low asynchronously; no FIFO write on the following edge.
  - After release, with requesters 2 and 0 valid, grant_id=0 is granted first (rr_ptr=0).
